conv_encoder_k3_framed: RTL and testbench
=========================================

Name: conv_encoder_k3_framed

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder with framing; the transmit-side counterpart of the Viterbi decoder.
- Accepts a frame of FRAME_LEN information bits over a valid/ready stream.
- Emits one 2-bit code symbol per bit, then appends K-1=2 zero tail bits so the decoder's 4-state trellis terminates in state 0.
- Symbol bit ordering matches the decoder's 2-bit branch-symbol convention.

Parameters:
- FRAME_LEN, 16: information bits per frame, range 1..1023.
- G0, 3'b111: generator for out_sym[1]. Bit2 taps the current input, bit1 the previous input, bit0 the input two steps back.
- G1, 3'b101: generator for out_sym[0], same tap order as G0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  encoder accepts in_bit this cycle.
- in_bit  input  1  information bit.
- out_valid  output  1  out_sym is valid.
- out_ready  input  1  downstream accepts out_sym.
- out_sym  output  2  code symbol {G0 parity, G1 parity}.
- out_last  output  1  marks the final tail symbol of the frame.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when the last symbol is accepted.

Behaviour:
- Reset (rst=1 at a clk edge) is synchronous and overrides everything, including a frame in progress:
  - state=IDLE, shift register sr[1:0]=0, bit counter=0.
  - out_valid=0, out_sym=0, out_last=0, in_ready=0, busy=0, frame_done=0.
  - A partially sent frame is discarded; nothing is flushed.
- Encoding: tap vector v={b, sr[0], sr[1]}, where b is the current bit, sr[0] the previous bit and sr[1] the bit before that.
  - sym[1] = XOR-reduce(v & G0); sym[0] = XOR-reduce(v & G1).
  - On each encode step: sr <= {sr[0], b}.
- Output register: one stage.
  - A symbol is "accepted" when out_valid & out_ready.
  - out_sym and out_last hold stable while out_valid=1 and out_ready=0.
  - The register can load when (!out_valid || out_ready), giving a sustained 1 symbol/cycle with latency 1 cycle (bit accepted at edge N, symbol valid after edge N).
- State machine: IDLE -> DATA -> TAIL -> DRAIN -> IDLE.
  - IDLE: in_ready=0. On start=1: clear sr and counter, go to DATA. start in any other state is ignored.
  - DATA: in_ready = (!out_valid || out_ready). On in_valid & in_ready: encode in_bit, load the output register, increment the counter. When the counter reaches FRAME_LEN, go to TAIL. in_valid while in_ready=0 is held off with no loss.
  - TAIL: in_ready=0. Encode internal b=0 whenever the output register can load, 2 steps total.
    - The second tail symbol is loaded with out_last=1; then go to DRAIN.
    - Upstream in_valid is ignored.
  - DRAIN: wait for acceptance of the out_last symbol. On acceptance: pulse frame_done=1 for 1 cycle, drop out_valid and out_last, go to IDLE.
  - DRAIN -> IDLE when start is asserted in that same cycle: the new frame is not started; start must be re-issued in IDLE.
- Symbols per frame: exactly FRAME_LEN+2; out_last is high on exactly one of them.
- Counter width: clog2(FRAME_LEN+1).
- Final encoder state after the tail is always sr=00.
- busy = (state != IDLE).

Test Plan:
- Basic frame: FRAME_LEN=4, out_ready=1, start then bits 1,0,1,1 back-to-back.
  - Required: out_sym sequence 11,10,00,01,01,11.
  - out_last only on the 6th symbol; frame_done pulses the cycle after the 6th acceptance; busy low afterwards.
- Backpressure: same frame, out_ready toggled 1,0,0,1,... pseudo-randomly.
  - Required: identical symbol sequence with no drops or duplicates.
  - out_sym stable whenever out_valid=1 and out_ready=0; in_ready=0 while the register is full and stalled.
- Input gaps: in_valid deasserted for 3 cycles between bits.
  - Required: same output sequence; no symbols emitted during the gaps.
- Mid-frame reset: rst=1 after the 2nd symbol of a FRAME_LEN=4 frame.
  - Required: next cycle out_valid=0, busy=0, in_ready=0.
  - A new start with bits 1,0,1,1 reproduces 11,10,00,01,01,11, confirming sr was cleared.
- Start handling: start pulsed while in DATA, and all-zero input with FRAME_LEN=16.
  - Required: the extra start has no effect.
  - The all-zero frame yields 18 symbols of 00, out_last on the 18th.
- Back-to-back frames: start issued in IDLE on the cycle after frame_done.
  - Required: the second frame is encoded from sr=00; its first symbol for bit 1 is 11.

Source files
------------

// File: rtl/conv_encoder_k3_framed.sv
// Rate-1/2, K=3 framed convolutional encoder: FRAME_LEN data symbols plus two
// zero-tail symbols per frame, so the 4-state trellis always ends in state 0.
module conv_encoder_k3_framed #(
  parameter int         FRAME_LEN = 16,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

  state_t           state, state_nx;
  logic [1:0]       sr;
  logic [CNT_W-1:0] cnt;
  logic             tail_step;
  logic             can_load;
  logic             in_fire;
  logic             tail_fire;
  logic             enc_bit;
  logic             sym_acc;

  // Tap vector is {current, previous, two-back}; MSB of each generator taps the current bit.
  function automatic logic [1:0] encode(input logic b, input logic [1:0] s);
    logic [2:0] v;
    v = {b, s[0], s[1]};
    return {^(v & G0), ^(v & G1)};
  endfunction

  assign can_load  = !out_valid || out_ready;
  assign sym_acc   = out_valid && out_ready;
  assign in_fire   = (state == DATA) && in_valid && can_load;
  assign tail_fire = (state == TAIL) && can_load;
  assign enc_bit   = (state == DATA) ? in_bit : 1'b0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = DATA;
      DATA: begin
        in_ready = can_load;
        if (in_fire && (cnt == CNT_W'(FRAME_LEN - 1))) state_nx = TAIL;
      end
      TAIL:  if (tail_fire && tail_step) state_nx = DRAIN;
      DRAIN: if (sym_acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= 2'b00;
      cnt        <= '0;
      tail_step  <= 1'b0;
      out_valid  <= 1'b0;
      out_sym    <= 2'b00;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if ((state == IDLE) && start) begin
        sr        <= 2'b00;
        cnt       <= '0;
        tail_step <= 1'b0;
      end
      // Single output stage: reload whenever empty or being drained this cycle.
      if (in_fire || tail_fire) begin
        out_sym   <= encode(enc_bit, sr);
        out_valid <= 1'b1;
        out_last  <= tail_fire && tail_step;
        sr        <= {sr[0], enc_bit};
      end else if (sym_acc) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (in_fire)   cnt       <= cnt + 1'b1;
      if (tail_fire) tail_step <= 1'b1;
      if ((state == DRAIN) && sym_acc) frame_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3_framed.sv
// Directed bench for conv_encoder_k3_framed: a FRAME_LEN=4 instance for most
// scenarios and a FRAME_LEN=16 instance for the all-zero / stray-start frame.
module tb_conv_encoder_k3_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, in_valid4, in_ready4, in_bit4, out_valid4, out_ready4;
  logic [1:0] out_sym4;
  logic       out_last4, busy4, frame_done4;
  logic       rst16, start16, in_valid16, in_ready16, in_bit16, out_valid16, out_ready16;
  logic [1:0] out_sym16;
  logic       out_last16, busy16, frame_done16;

  conv_encoder_k3_framed #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_bit(in_bit4), .out_valid(out_valid4), .out_ready(out_ready4), .out_sym(out_sym4),
    .out_last(out_last4), .busy(busy4), .frame_done(frame_done4));

  conv_encoder_k3_framed #(.FRAME_LEN(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_bit(in_bit16), .out_valid(out_valid16), .out_ready(out_ready16), .out_sym(out_sym16),
    .out_last(out_last16), .busy(busy16), .frame_done(frame_done16));

  int errors = 0;
  int checks = 0;

  logic       bits[4];
  logic [1:0] exp_a[6];
  logic [1:0] exp_b[6];
  logic       bp_pat[16];
  logic [1:0] got_sym[$];
  logic       got_last[$];
  int         stall_bad, ready_bad, last_acc_cyc, done_cyc;
  logic       busy_at_done;
  bit         timed_out;

  // Runs one FRAME_LEN=4 frame on dut4 and records what comes out.
  task automatic drive_frame(input int gap, input bit bp);
    int   bi, gapc, cyc;
    logic prev_stall;
    logic [1:0] prev_sym;
    got_sym.delete();
    got_last.delete();
    stall_bad = 0; ready_bad = 0; last_acc_cyc = -10; done_cyc = -1;
    busy_at_done = 1'bx; timed_out = 1'b1;
    @(negedge clk);
    start4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bi = 0; gapc = 0; cyc = 0; prev_stall = 1'b0; prev_sym = 2'b00;
    while (cyc < 200) begin
      out_ready4 = bp ? bp_pat[cyc % 16] : 1'b1;
      if (bi < 4 && gapc == 0) begin
        in_valid4 = 1'b1; in_bit4 = bits[bi];
      end else begin
        in_valid4 = 1'b0; in_bit4 = 1'b0;
      end
      #1;
      if (prev_stall && out_sym4 !== prev_sym) stall_bad++;
      if (out_valid4 && !out_ready4 && in_ready4) ready_bad++;
      if (frame_done4) begin
        done_cyc = cyc; busy_at_done = busy4; timed_out = 1'b0;
        break;
      end
      if (out_valid4 && out_ready4) begin
        got_sym.push_back(out_sym4);
        got_last.push_back(out_last4);
        if (out_last4) last_acc_cyc = cyc;
      end
      if (in_valid4 && in_ready4) begin
        bi++; gapc = gap;
      end else if (!in_valid4 && gapc > 0) begin
        gapc--;
      end
      prev_stall = out_valid4 && !out_ready4;
      prev_sym   = out_sym4;
      @(negedge clk);
      cyc++;
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst16 = 1'b1;
    start4 = 0; in_valid4 = 0; in_bit4 = 0; out_ready4 = 1;
    start16 = 0; in_valid16 = 0; in_bit16 = 0; out_ready16 = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4); end
    checks++; if (out_sym4 !== 2'b00) begin errors++; $display("FAIL reset_out_sym: got %b expected 00", out_sym4); end
    checks++; if (out_last4 !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last4); end
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (frame_done4 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done4); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    rst4 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b expected 0", in_ready4); end
  endtask

  task automatic test_basic();
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_frame(0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no frame_done expected one"); end
    checks++; if (got_sym.size() !== 6) begin errors++; $display("FAIL basic_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_sym.size() || got_sym[i] !== exp_a[i]) begin
        errors++; $display("FAIL basic_sym%0d: got %b expected %b", i, (i < got_sym.size()) ? got_sym[i] : 2'bxx, exp_a[i]);
      end
      checks++;
      if (i >= got_last.size() || got_last[i] !== (i == 5)) begin
        errors++; $display("FAIL basic_last%0d: got %b expected %b", i, (i < got_last.size()) ? got_last[i] : 1'bx, (i == 5));
      end
    end
    checks++; if (done_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_acc_cyc + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_frame(0, 1'b1);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got no frame_done expected one"); end
    checks++; if (got_sym.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_sym.size() || got_sym[i] !== exp_a[i]) begin
        errors++; $display("FAIL bp_sym%0d: got %b expected %b", i, (i < got_sym.size()) ? got_sym[i] : 2'bxx, exp_a[i]);
      end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stall_bad); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL bp_in_ready: got %0d stalled-ready cycles expected 0", ready_bad); end
    checks++; if (got_last.size() != 6 || got_last[5] !== 1'b1) begin errors++; $display("FAIL bp_last: got size %0d expected last on 6th", got_last.size()); end
  endtask

  task automatic test_gaps();
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_frame(3, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL gap_timeout: got no frame_done expected one"); end
    checks++; if (got_sym.size() !== 6) begin errors++; $display("FAIL gap_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_sym.size() || got_sym[i] !== exp_a[i]) begin
        errors++; $display("FAIL gap_sym%0d: got %b expected %b", i, (i < got_sym.size()) ? got_sym[i] : 2'bxx, exp_a[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start4 = 1'b1; out_ready4 = 1'b1; in_valid4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0; in_valid4 = 1'b1; in_bit4 = 1'b1;
    @(negedge clk);
    in_bit4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    checks++; if (out_sym4 !== 2'b10 || out_valid4 !== 1'b1) begin errors++; $display("FAIL mr_second_sym: got %b/%b expected 10/1", out_sym4, out_valid4); end
    rst4 = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL mr_out_valid: got %b expected 0", out_valid4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", busy4); end
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL mr_in_ready: got %b expected 0", in_ready4); end
    rst4 = 1'b0;
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_frame(0, 1'b0);
    checks++; if (got_sym.size() !== 6) begin errors++; $display("FAIL mr_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_sym.size() || got_sym[i] !== exp_a[i]) begin
        errors++; $display("FAIL mr_sym%0d: got %b expected %b", i, (i < got_sym.size()) ? got_sym[i] : 2'bxx, exp_a[i]);
      end
    end
  endtask

  task automatic test_start_in_data();
    int bi, cyc, nsym, nlast, last_pos, nonzero;
    bit done;
    bi = 0; cyc = 0; nsym = 0; nlast = 0; last_pos = -1; nonzero = 0; done = 0;
    @(negedge clk);
    start16 = 1'b1; out_ready16 = 1'b1; in_valid16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    while (cyc < 200) begin
      start16    = (bi == 4);
      in_valid16 = (bi < 16);
      in_bit16   = 1'b0;
      #1;
      if (frame_done16) begin done = 1; break; end
      if (out_valid16 && out_ready16) begin
        nsym++;
        if (out_sym16 !== 2'b00) nonzero++;
        if (out_last16) begin nlast++; last_pos = nsym; end
      end
      if (in_valid16 && in_ready16) bi++;
      @(negedge clk);
      cyc++;
    end
    start16 = 1'b0; in_valid16 = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL zero_timeout: got no frame_done expected one"); end
    checks++; if (nsym !== 18) begin errors++; $display("FAIL zero_count: got %0d expected 18", nsym); end
    checks++; if (nonzero !== 0) begin errors++; $display("FAIL zero_syms: got %0d nonzero expected 0", nonzero); end
    checks++; if (nlast !== 1 || last_pos !== 18) begin errors++; $display("FAIL zero_last: got %0d at %0d expected 1 at 18", nlast, last_pos); end
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b expected 0", busy16); end
  endtask

  task automatic test_back_to_back();
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive_frame(0, 1'b0);
    bits = '{1'b1, 1'b1, 1'b0, 1'b0};
    drive_frame(0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got no frame_done expected one"); end
    checks++; if (got_sym.size() !== 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_sym.size() || got_sym[i] !== exp_b[i]) begin
        errors++; $display("FAIL b2b_sym%0d: got %b expected %b", i, (i < got_sym.size()) ? got_sym[i] : 2'bxx, exp_b[i]);
      end
    end
  endtask

  initial begin
    exp_a  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    exp_b  = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_start_in_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
